// File: rtl/maxpool_2x2_window_reducer.sv
// -----------------------------------------------------------------------------
// maxpool_2x2_window_reducer
//
// Sits after the 2x2 sliding-window FIFO. For each FIFO shift it tracks the
// pixel position in the frame. It flags the shifts that complete a
// stride-aligned 2x2 window, and it reduces that window's four taps to one
// signed maximum. The block is fully pipelined: it accepts one window per
// clock and has no backpressure.
//
// Optional feature macro: POOL_RELU_EN
//   defined   -> the output stage clamps negative maxima to 0 (fused ReLU)
//   undefined -> raw signed maximum; no clamp logic is built
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high
//   in_valid    in   one pixel shifted into the window FIFO (fifo_enable)
//   win_1..4    in   window FIFO taps (fifo_data_out_1..4), signed
//   out_data    out  pooled result; holds its last value between windows
//   out_valid   out  one-cycle pulse per emitted window
//   out_row     out  output row index of out_data
//   out_col     out  output column index of out_data
//   frame_done  out  pulses together with the last window of a frame
//
// Timing, with the pixel sampled at edge E0
//   E0: candidate flag and output indices are registered.
//       The FIFO taps also update at this edge.
//   E1: stage 1 takes the pairwise maxima of the taps.
//       These are the taps as they stood before any FIFO update at E1.
//   E2: the final maximum and out_valid are registered.
//
// Only KERNAL_SIZE = 2 is meaningful; the reduction tree is fixed at 4 taps.
// -----------------------------------------------------------------------------
module maxpool_2x2_window_reducer #(
   parameter int DATA_WIDTH  = 32,
   parameter int IFM_SIZE    = 7,
   parameter int KERNAL_SIZE = 2,
   parameter int STRIDE      = 2,
   localparam int OFM_SIZE   = (IFM_SIZE - KERNAL_SIZE) / STRIDE + 1,
   localparam int IDX_W      = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] win_1,
   input  logic [DATA_WIDTH-1:0] win_2,
   input  logic [DATA_WIDTH-1:0] win_3,
   input  logic [DATA_WIDTH-1:0] win_4,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic [IDX_W-1:0]      out_row,
   output logic [IDX_W-1:0]      out_col,
   output logic                  frame_done
);

   localparam int CNT_W = $clog2(IFM_SIZE);
   localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(IFM_SIZE - 1);
   localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(STRIDE - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OFM_SIZE - 1);

   // Pixel position of the next shift.
   logic [CNT_W-1:0] col;
   logic [CNT_W-1:0] row;

   // Stride phase and output index. Together they stand for (c-1)%STRIDE and
   // (c-1)/STRIDE, and likewise for rows; both are only meaningful when the
   // position is >= 1. Running counters avoid generic dividers and modulo
   // logic for non-power-of-two strides.
   logic [PH_W-1:0]  col_ph;
   logic [PH_W-1:0]  row_ph;
   logic [IDX_W-1:0] ocol;
   logic [IDX_W-1:0] orow;

   // E0 stage
   logic             cand;
   logic [IDX_W-1:0] cand_row;
   logic [IDX_W-1:0] cand_col;

   // E1 stage
   logic                  s1_valid;
   logic                  s1_last;
   logic [DATA_WIDTH-1:0] m12;
   logic [DATA_WIDTH-1:0] m34;
   logic [IDX_W-1:0]      s1_row;
   logic [IDX_W-1:0]      s1_col;

   // E2 combinational result
   logic [DATA_WIDTH-1:0] pool_max;
   logic [DATA_WIDTH-1:0] result;

   function automatic logic [DATA_WIDTH-1:0] smax(
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   // Position tracking and window detection (E0)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col      <= '0;
         row      <= '0;
         col_ph   <= '0;
         row_ph   <= '0;
         ocol     <= '0;
         orow     <= '0;
         cand     <= 1'b0;
         cand_row <= '0;
         cand_col <= '0;
      end else if (in_valid) begin
         cand     <= (row != '0) && (col != '0) && (row_ph == '0) && (col_ph == '0);
         cand_row <= orow;
         cand_col <= ocol;

         if (col == LAST_POS) begin
            col    <= '0;
            col_ph <= '0;
            ocol   <= '0;
            if (row == LAST_POS) begin
               row    <= '0;
               row_ph <= '0;
               orow   <= '0;
            end else begin
               row <= row + 1'b1;
               // The step from position 0 to 1 leaves phase/index at 0.
               if (row != '0) begin
                  if (row_ph == LAST_PH) begin
                     row_ph <= '0;
                     orow   <= orow + 1'b1;
                  end else begin
                     row_ph <= row_ph + 1'b1;
                  end
               end
            end
         end else begin
            col <= col + 1'b1;
            if (col != '0) begin
               if (col_ph == LAST_PH) begin
                  col_ph <= '0;
                  ocol   <= ocol + 1'b1;
               end else begin
                  col_ph <= col_ph + 1'b1;
               end
            end
         end
      end else begin
         cand <= 1'b0;
      end
   end

   // Stage 1: pairwise maxima (E1)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         m12      <= '0;
         m34      <= '0;
         s1_row   <= '0;
         s1_col   <= '0;
      end else begin
         s1_valid <= cand;
         if (cand) begin
            m12     <= smax(win_1, win_2);
            m34     <= smax(win_3, win_4);
            s1_row  <= cand_row;
            s1_col  <= cand_col;
            s1_last <= (cand_row == LAST_IDX) && (cand_col == LAST_IDX);
         end
      end
   end

   always_comb begin
      pool_max = smax(m12, m34);
`ifdef POOL_RELU_EN
      result = pool_max[DATA_WIDTH-1] ? '0 : pool_max;
`else
      result = pool_max;
`endif
   end

   // Stage 2: final maximum and output registers (E2)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_row    <= '0;
         out_col    <= '0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= s1_valid;
         frame_done <= s1_valid && s1_last;
         if (s1_valid) begin
            out_data <= result;
            out_row  <= s1_row;
            out_col  <= s1_col;
         end
      end
   end

endmodule

// File: tb/tb_maxpool_2x2_window_reducer.sv
// -----------------------------------------------------------------------------
// Bench for maxpool_2x2_window_reducer (IFM 7, K 2, S 2, 32-bit data).
// A behavioural window FIFO builds the taps from a frame image. Every
// completed window pushes an expected record onto a queue, holding the value,
// indices, last flag and due cycle. A negedge monitor compares each cycle's
// outputs against the head of that queue.
// -----------------------------------------------------------------------------
module tb_maxpool_2x2_window_reducer;

   localparam int DW  = 32;
   localparam int IFM = 7;
   localparam int S   = 2;
   localparam int OFM = (IFM - 2) / S + 1;
   localparam int NV  = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [DW-1:0] win_1, win_2, win_3, win_4;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic [1:0]    out_row, out_col;
   logic          frame_done;

   maxpool_2x2_window_reducer #(
      .DATA_WIDTH (DW),
      .IFM_SIZE   (IFM),
      .KERNAL_SIZE(2),
      .STRIDE     (S)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .win_1     (win_1),
      .win_2     (win_2),
      .win_3     (win_3),
      .win_4     (win_4),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_row   (out_row),
      .out_col   (out_col),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] w1, w2, w3, w4;
      logic [DW-1:0] exp_raw, exp_relu;
   } vec_t;

   typedef struct {
      longint        due;
      logic [DW-1:0] data;
      logic [1:0]    row, col;
      logic          last;
   } exp_t;

   vec_t   vecs[NV];
   exp_t   sb[$];
   int     exp_seq[9];
   int     img[IFM][IFM];
   int     tests = 0;
   int     fails = 0;
   int     pr = 0, pc = 0;
   longint cyc = 0;
   bit     mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Signed maximum of the four taps, with the optional clamp.
   function automatic logic [DW-1:0] ref_max(input logic [DW-1:0] a, b, c, d);
      int m;
      m = a;
      if (int'(b) > m) m = b;
      if (int'(c) > m) m = c;
      if (int'(d) > m) m = d;
`ifdef POOL_RELU_EN
      if (m < 0) m = 0;
`endif
      return m;
   endfunction

   function automatic bit is_cand(input int r, input int c);
      return r >= 1 && c >= 1 && (r - 1) % S == 0 && (c - 1) % S == 0;
   endfunction

   // One FIFO shift. The taps change just after the sampling edge, as the
   // window FIFO output would.
   task automatic pulse(input logic [DW-1:0] a, b, c, d, input bit use_exp,
                        input logic [DW-1:0] ev, input int gap);
      exp_t e;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      win_1 = a; win_2 = b; win_3 = c; win_4 = d;
      if (is_cand(pr, pc)) begin
         e.due  = cyc + 2;
         e.data = use_exp ? ev : ref_max(a, b, c, d);
         e.row  = 2'((pr - 1) / S);
         e.col  = 2'((pc - 1) / S);
         e.last = (e.row == 2'(OFM - 1)) && (e.col == 2'(OFM - 1));
         sb.push_back(e);
      end
      pc++;
      if (pc == IFM) begin
         pc = 0;
         pr++;
         if (pr == IFM) pr = 0;
      end
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive n pixels from an image. For mode 0 the image is the raster count
   // 1..49 and the expected values come from the constant table. Mode 1 uses
   // a random image. gap < 0 picks a random gap of 0..2 cycles per pixel.
   task automatic run_frame(input int mode, input int gap, input int n);
      int r, c, g, k;
      logic [DW-1:0] t1, t2, t3, t4;
      for (int y = 0; y < IFM; y++)
         for (int x = 0; x < IFM; x++)
            img[y][x] = (mode == 0) ? y * IFM + x + 1 : int'($urandom);
      for (int i = 0; i < n; i++) begin
         r = pr; c = pc;
         if (r >= 1 && c >= 1) begin
            t1 = img[r-1][c-1]; t2 = img[r-1][c]; t3 = img[r][c-1]; t4 = img[r][c];
         end else begin
            t1 = $urandom; t2 = $urandom; t3 = $urandom; t4 = $urandom;
         end
         k = (r >= 1 && c >= 1) ? ((r - 1) / S) * OFM + (c - 1) / S : 0;
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         pulse(t1, t2, t3, t4, mode == 0, exp_seq[k], g);
      end
   endtask

   always @(negedge clk) begin : monitor
      bit   exp_ov;
      exp_t h;
      if (mon_en) begin
         exp_ov = 1'b0;
         while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
         if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_ov = 1'b1;
            h = sb.pop_front();
         end
         check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
         if (exp_ov && out_valid) begin
            check("out_data", out_data, h.data);
            check("out_row", {30'b0, out_row}, {30'b0, h.row});
            check("out_col", {30'b0, out_col}, {30'b0, h.col});
            check("frame_done", {31'b0, frame_done}, {31'b0, h.last});
         end else if (!exp_ov && !out_valid) begin
            check("frame_done_idle", {31'b0, frame_done}, 32'd0);
         end
      end
   end

   initial begin
      int vi;
      logic [DW-1:0] ev;

      exp_seq = '{9, 11, 13, 23, 25, 27, 37, 39, 41};
      vecs[0] = '{32'hFFFFFFFB, 32'hFFFFFFFD, 32'hFFFFFFF7, 32'hFFFFFFF9, 32'hFFFFFFFD, 32'h0};
      vecs[1] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
      vecs[2] = '{32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
      vecs[3] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
      vecs[4] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
      vecs[5] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h4, 32'h4};
      vecs[6] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h0};
      vecs[7] = '{32'h0, 32'hFFFFFFFF, 32'h5, 32'hFFFFFF9C, 32'h5, 32'h5};
      vecs[8] = '{32'h64, 32'hFFFFFF38, 32'h12C, 32'hFFFFFE70, 32'h12C, 32'h12C};
      vecs[9] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h0};

      reset = 1'b1;
      in_valid = 1'b0;
      win_1 = '0; win_2 = '0; win_3 = '0; win_4 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_out_data", out_data, 32'd0);
      check("reset_out_row", {30'b0, out_row}, 32'd0);
      check("reset_out_col", {30'b0, out_col}, 32'd0);
      check("reset_frame_done", {31'b0, frame_done}, 32'd0);
      reset = 1'b0;
      mon_en = 1'b1;

      // Raster frame, back-to-back, then every third cycle.
      run_frame(0, 0, IFM * IFM);
      run_frame(0, 2, IFM * IFM);

      // Table vectors at candidate shifts; other shifts carry junk taps.
      vi = 0;
      while (vi < NV || pr != 0 || pc != 0) begin
         if (vi < NV && is_cand(pr, pc)) begin
`ifdef POOL_RELU_EN
            ev = vecs[vi].exp_relu;
`else
            ev = vecs[vi].exp_raw;
`endif
            pulse(vecs[vi].w1, vecs[vi].w2, vecs[vi].w3, vecs[vi].w4, 1'b1, ev, 0);
            vi++;
         end else begin
            pulse($urandom, $urandom, $urandom, $urandom, 1'b0, '0, 0);
         end
      end

      // Random images: two continuous frames, then one with random gaps.
      run_frame(1, 0, 2 * IFM * IFM);
      run_frame(1, -1, IFM * IFM);

      // Reset right after a candidate pixel (23, at row 3 col 1) is sampled.
      run_frame(0, 0, 23);
      reset = 1'b1;
      sb.delete();
      pr = 0; pc = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      run_frame(0, 0, IFM * IFM);

      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
